// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared PS/2 definitions. Contents are the host transmitter
//            state encoding, the frame edge numbering, the odd-parity helper
//            and the retry limit.
// Options  : the retry limit is only used when PS2_TX_RETRY_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQUEST = 3'd2,
    ST_FRAME   = 3'd3,
    ST_RELEASE = 3'd4
  } ps2_state_e;

  // Device falling-edge numbering within one host-to-device frame
  localparam int DATA_BITS   = 8;
  localparam int PARITY_EDGE = 9;
  localparam int STOP_EDGE   = 10;
  localparam int ACK_EDGE    = 11;

  // Extra attempts after a NACK or timeout when retries are built in
  localparam int RETRY_LIMIT = 2;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_sync
// Purpose  : Two-flop synchronisers for the raw PS2_CLK and PS2_DATA pins.
//            Also provides a falling-edge strobe on the synchronised clock.
//            The block is shared with the keyboard receive path.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta_q,  clk_meta_d;
  logic clk_sync_q,  clk_sync_d;
  logic clk_prev_q,  clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  // Each pin advances one stage along its synchroniser chain per cycle
  always_comb begin
    clk_meta_d  = clk_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = data_in;
    data_sync_d = data_meta_q;
  end

  // Chain registers reset to the idle-high bus level so reset makes no false edge
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign clk_sync  = clk_sync_q;
  assign data_sync = data_sync_q;
  assign clk_fall  = clk_prev_q & ~clk_sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device transmitter. It inhibits the bus, issues a
//            request-to-send and then shifts one command byte, odd parity and
//            the stop bit out on device clock edges. It then checks the
//            device ACK.
// Options  : PS2_TX_RETRY_EN - retry a NACK/timeout up to RETRY_LIMIT times
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  import ps2_pkg::*;

  localparam int MAX_A      = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       ACK_PREV     = 4'(ACK_EDGE - 1);
  localparam logic [3:0]       PARITY_E     = 4'(PARITY_EDGE);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic [8:0]       frame_q, frame_d;      // {parity, data}
  logic             clk_drive_q, clk_drive_d;
  logic             data_drive_q, data_drive_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             fail;
  logic             tx_bit;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic clk_sync, data_sync, clk_fall;

  ps2_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  // Sequencing: phase timing, device edge counting, ACK check and abort handling
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    fail    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_INHIBIT;
          frame_d = {odd_parity(tx_data), tx_data};
`ifdef PS2_TX_RETRY_EN
          retry_d = 2'd0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          state_d = ST_REQUEST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REQUEST: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_FRAME;
          cnt_d   = '0;
          edge_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FRAME: begin
        if (clk_fall) begin
          cnt_d  = '0;
          edge_d = edge_q + 4'd1;
          // The device holds data low across the ACK clock pulse
          if (edge_q == ACK_PREV) begin
            if (!data_sync) state_d = ST_RELEASE;
            else            fail    = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (clk_sync && data_sync) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q < 2'(RETRY_LIMIT)) begin
        retry_d = retry_q + 2'd1;
        state_d = ST_INHIBIT;
        cnt_d   = '0;
        edge_d  = '0;
      end else begin
        state_d = ST_IDLE;
        error_d = 1'b1;
      end
`else
      state_d = ST_IDLE;
      error_d = 1'b1;
`endif
    end

    if (state_d == ST_IDLE) begin
      cnt_d  = '0;
      edge_d = '0;
    end
  end

  // Line drive for the upcoming cycle, so each pin changes together with the state
  always_comb begin
    tx_bit = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (edge_d == 4'(i + 1)) tx_bit = frame_d[i[3:0]];
    end
    clk_drive_d  = (state_d == ST_INHIBIT) || (state_d == ST_REQUEST);
    data_drive_d = 1'b0;
    case (state_d)
      ST_REQUEST: data_drive_d = 1'b1;
      ST_FRAME: begin
        if (edge_d == 4'd0)           data_drive_d = 1'b1;     // start bit still held
        else if (edge_d <= PARITY_E)  data_drive_d = ~tx_bit;  // data bits, then parity
        else                          data_drive_d = 1'b0;     // stop bit: release
      end
      default: data_drive_d = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      edge_q       <= '0;
      frame_q      <= '0;
      clk_drive_q  <= 1'b0;
      data_drive_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q      <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edge_q       <= edge_d;
      frame_q      <= frame_d;
      clk_drive_q  <= clk_drive_d;
      data_drive_q <= data_drive_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef PS2_TX_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign tx_ready           = (state_q == ST_IDLE);
  assign busy               = (state_q != ST_IDLE);
  assign ps2_clk_drive_low  = clk_drive_q;
  assign ps2_data_drive_low = data_drive_q;
  assign tx_done            = done_q;
  assign tx_error           = error_q;

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared PS2_CLK/PS2_DATA lines.
- Counterpart of the keyboard receive path; drives both lines open-drain through top-level tristates.
- Exposes `busy` so the receive path can discard frames while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 12000, cycles clock line is held low before request (120 us at 100 MHz).
- SETUP_CYCLES, 200, cycles data is held low with clock still low before clock release.
- TIMEOUT_CYCLES, 2000000, max cycles between device clock falling edges, or until final line release, before abort.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  byte offered.
- tx_ready  out  1  block can accept a byte.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_data_in  in  1  raw PS2_DATA pin level (asynchronous).
- ps2_clk_drive_low  out  1  1 = pull PS2_CLK low, 0 = release (hi-Z).
- ps2_data_drive_low  out  1  1 = pull PS2_DATA low, 0 = release.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: device acknowledged the byte.
- tx_error  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset, effective on the next edge:
  - state IDLE; all counters 0.
  - both drive_low outputs 0.
  - tx_ready=1, busy=0, tx_done=0, tx_error=0.
- Reset mid-frame: lines released on the next edge; no done/error pulse.
- Input synchronisation: both pins pass through 2-flop synchronisers. A falling edge is prev=1 and cur=0 on the synchronised clock, which gives 2–3 cycles of latency.
- Handshake:
  - Byte is accepted when tx_valid && tx_ready on a clock edge.
  - tx_ready=1 only in IDLE.
  - tx_data is latched on acceptance, together with parity = ~^tx_data (odd parity).
  - tx_valid outside IDLE is ignored.
- States and transitions:
  - IDLE: lines released. Accept → INHIBIT.
  - INHIBIT: clk low, data released, for INHIBIT_CYCLES cycles → REQUEST.
  - REQUEST: clk low, data low (start bit), for SETUP_CYCLES cycles → FRAME.
  - FRAME: clk released; edge counter n=0.
    - On each device falling edge n increments; after edge n the data line is updated:
      - n=1..8: tx_data[n-1], LSB first.
      - n=9: parity.
      - n=10: released (stop bit).
    - Bit encoding: drive_low = ~bit.
    - On edge 11: sample the synchronised data line. 0 → RELEASE; 1 → NACK error.
  - RELEASE: wait until synchronised clk=1 and data=1 → IDLE with a tx_done pulse.
- Timeout: one counter, cleared on entering FRAME and on every falling edge. If it reaches TIMEOUT_CYCLES in FRAME or RELEASE → release lines, tx_error pulse, IDLE.
- tx_done and tx_error are mutually exclusive and last exactly one cycle.
- INHIBIT and REQUEST ignore device clock edges.

Optional Feature:
- PS2_TX_RETRY_EN.
- Defined: on NACK or timeout, the block re-enters INHIBIT with the latched byte, up to 2 retries (3 attempts total). tx_error pulses only after the final failure; tx_done pulses on any successful attempt. busy stays high throughout.
- Undefined: the first failure produces a tx_error pulse immediately and returns to IDLE.

Decomposition:
- Package ps2_pkg:
  - state encoding.
  - frame constants: DATA_BITS=8, PARITY_EDGE=9, STOP_EDGE=10, ACK_EDGE=11.
  - odd-parity function.
  - retry limit of 2.
- Sub-module ps2_line_sync: 2-flop synchroniser plus falling-edge detector for the clock line, and synchroniser for the data line. The receive path reuses it.

Test Plan:
- Device model at 12.5 kHz (40 us half period), tx_data=0xED, which has six 1-bits so parity=1.
  - Required: clk held low exactly 12000+200 cycles.
  - Required: data low from REQUEST.
  - Required: bits sampled on device rising edges = 1,0,1,1,0,1,1,1.
  - Required: parity bit = 1, then stop = 1.
  - Required: ACK=0 at edge 11 → single tx_done pulse, tx_ready=1 again.
- tx_data=0xFF: parity=1; tx_data=0x00: parity=1, all data bits driven low; both complete with tx_done.
- Device holds data high at edge 11 → tx_error pulse, no tx_done, lines released.
  - With PS2_TX_RETRY_EN: 3 full INHIBIT sequences, then one tx_error.
- Device never clocks after clk release → tx_error exactly 2000000 cycles after FRAME entry, both drive_low=0.
- reset asserted after falling edge 4 → next cycle both lines released, busy=0, tx_ready=1, no pulses; a new byte then transmits correctly.
- tx_valid held high during a transmission with a different byte → not accepted (tx_ready=0); the original byte completes. The second byte is accepted only after returning to IDLE.
